// File: rtl/hazard_scoreboard.sv
// ID-stage register scoreboard: per-register countdown until a pending result is
// bypassable, driving the RAW/WAW stall request for variable-latency producers.
module hazard_scoreboard #(
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_LAT   = 4,
  parameter int LAT_W     = $clog2(MAX_LAT + 1),
  parameter int PERF_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 flush,
  input  logic                 issue_valid,
  input  logic                 issue_wreg,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic [LAT_W-1:0]     issue_lat,
  input  logic                 src1_read,
  input  logic [ADDR_W-1:0]    src1_addr,
  input  logic                 src2_read,
  input  logic [ADDR_W-1:0]    src2_addr,
  output logic                 stallreq,
  output logic [REG_COUNT-1:0] busy_vec,
  output logic [PERF_W-1:0]    stall_cycles
);

  logic [LAT_W-1:0]     cnt_r     [REG_COUNT];
  logic [LAT_W-1:0]     cnt_nxt_s [REG_COUNT];
  logic [LAT_W-1:0]     src1_cnt_s, src2_cnt_s, rd_cnt_s, lat_e_s;
  logic                 live_s, raw1_s, raw2_s, waw_s, accept_s, record_s;
  logic [REG_COUNT-1:0] busy_nxt_s;

  // Look up pending counts for both sources and the destination.
  always_comb begin
    src1_cnt_s = '0;
    src2_cnt_s = '0;
    rd_cnt_s   = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      if (src1_addr == ADDR_W'(r)) src1_cnt_s = cnt_r[r];
      else                         src1_cnt_s = src1_cnt_s;
      if (src2_addr == ADDR_W'(r)) src2_cnt_s = cnt_r[r];
      else                         src2_cnt_s = src2_cnt_s;
      if (issue_rd == ADDR_W'(r))  rd_cnt_s   = cnt_r[r];
      else                         rd_cnt_s   = rd_cnt_s;
    end
  end

  // Hazard detection and issue acceptance.
  always_comb begin
    lat_e_s  = (issue_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : issue_lat;
    live_s   = issue_valid & ~flush & ~rst;
    raw1_s   = src1_read & (src1_cnt_s != '0);
    raw2_s   = src2_read & (src2_cnt_s != '0);
    // A later write may only overtake a pending one if it lands no earlier.
    waw_s    = issue_wreg & (issue_rd != '0) & (rd_cnt_s > lat_e_s);
    stallreq = live_s & (raw1_s | raw2_s | waw_s);
    accept_s = live_s & ~stallreq & ~hold;
    record_s = accept_s & issue_wreg & (issue_rd != '0) & (lat_e_s != '0);
  end

  // Next-state counters: decrement, with a recorded issue overriding the decrement.
  always_comb begin
    cnt_nxt_s     = cnt_r;
    busy_nxt_s    = '0;
    cnt_nxt_s[0]  = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      if (hold)                                   cnt_nxt_s[r] = cnt_r[r];
      else if (record_s && issue_rd == ADDR_W'(r)) cnt_nxt_s[r] = lat_e_s;
      else if (cnt_r[r] != '0)                    cnt_nxt_s[r] = cnt_r[r] - LAT_W'(1);
      else                                        cnt_nxt_s[r] = cnt_r[r];
      busy_nxt_s[r] = (cnt_nxt_s[r] != '0);
    end
  end

  // State, busy mirror and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= '{default: '0};
      busy_vec     <= '0;
      stall_cycles <= '0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      busy_vec <= busy_nxt_s;
      if (stallreq && stall_cycles != {PERF_W{1'b1}})
        stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: hand-computed expectations for load-use,
// multi-cycle RAW, hold, WAW, r0, flush, saturation and mid-stall reset.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst, hold, flush, issue_valid, issue_wreg;
  logic [4:0]  issue_rd, src1_addr, src2_addr;
  logic [2:0]  issue_lat;
  logic        src1_read, src2_read, stallreq;
  logic [31:0] busy_vec;
  logic [15:0] stall_cycles;
  int          n_vec = 0;
  int          n_err = 0;
  int          stalls;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .issue_valid(issue_valid), .issue_wreg(issue_wreg), .issue_rd(issue_rd),
    .issue_lat(issue_lat), .src1_read(src1_read), .src1_addr(src1_addr),
    .src2_read(src2_read), .src2_addr(src2_addr), .stallreq(stallreq),
    .busy_vec(busy_vec), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID-stage instruction and let combinational outputs settle.
  task automatic drive(input logic v, input logic w, input logic [4:0] rd, input logic [2:0] lat,
                       input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2);
    issue_valid = v; issue_wreg = w; issue_rd = rd; issue_lat = lat;
    src1_read = r1; src1_addr = a1; src2_read = r2; src2_addr = a2;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  // Count stalled cycles until the instruction in ID is accepted (bounded).
  task automatic count_stalls(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!stallreq) break;
      n++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 3'd1, 1'b1, 5'd3, 1'b1, 5'd4);
    check_vec("stall_in_reset", {31'd0, stallreq}, 32'd0);
    step(); step();
    check_vec("reset_busy", busy_vec, 32'd0);
    check_vec("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    rst = 1'b0;

    // Load-use: LW r3 then ADDU r4,r3,r3
    drive(1'b1, 1'b1, 5'd3, 3'd1, 1'b0, 5'd0, 1'b0, 5'd0);
    check_vec("lw_no_stall", {31'd0, stallreq}, 32'd0);
    step();
    check_vec("lw_busy3", busy_vec, 32'h0000_0008);
    drive(1'b1, 1'b1, 5'd4, 3'd0, 1'b1, 5'd3, 1'b1, 5'd3);
    check_vec("addu_stall_t1", {31'd0, stallreq}, 32'd1);
    step();
    check_vec("addu_go_t2", {31'd0, stallreq}, 32'd0);
    check_vec("lw_busy_clear", busy_vec, 32'd0);
    check_vec("lw_stall_cycles", {16'd0, stall_cycles}, 32'd1);
    step();

    // MUL r5 then reader: two bubbles
    drive(1'b1, 1'b1, 5'd5, 3'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive(1'b1, 1'b0, 5'd0, 3'd0, 1'b1, 5'd5, 1'b0, 5'd0);
    count_stalls(stalls);
    check_vec("mul_stalls", stalls, 32'd2);
    step();

    // Same with a three-cycle hold mid-stall
    drive(1'b1, 1'b1, 5'd5, 3'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive(1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 1'b1, 5'd5);
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      hold = (i >= 1 && i <= 3);
      #1;
      if (!stallreq) break;
      stalls++;
      step();
      if (i == 3) check_vec("hold_frozen_busy", busy_vec, 32'h0000_0020);
    end
    hold = 1'b0;
    check_vec("hold_stalls", stalls, 32'd5);
    check_vec("hold_stall_cycles", {16'd0, stall_cycles}, 32'd8);
    step();

    // WAW: MUL r6 then ADDU r6 (no r6 read)
    drive(1'b1, 1'b1, 5'd6, 3'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive(1'b1, 1'b1, 5'd6, 3'd0, 1'b1, 5'd1, 1'b0, 5'd0);
    count_stalls(stalls);
    check_vec("waw_stalls", stalls, 32'd2);
    step();
    // Longer-latency rewrite of a pending register is not a WAW hazard
    drive(1'b1, 1'b1, 5'd6, 3'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive(1'b1, 1'b1, 5'd6, 3'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    check_vec("waw_longer_ok", {31'd0, stallreq}, 32'd0);
    step();
    drive(1'b1, 1'b0, 5'd0, 3'd0, 1'b1, 5'd6, 1'b0, 5'd0);
    count_stalls(stalls);
    check_vec("override_stalls", stalls, 32'd3);
    step();

    // Latency above MAX_LAT clamps to 4
    drive(1'b1, 1'b1, 5'd8, 3'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive(1'b1, 1'b0, 5'd0, 3'd0, 1'b1, 5'd8, 1'b0, 5'd0);
    count_stalls(stalls);
    check_vec("clamp_stalls", stalls, 32'd4);
    check_vec("clamp_stall_cycles", {16'd0, stall_cycles}, 32'd17);
    step();

    // Writes to r0 never create an entry
    drive(1'b1, 1'b1, 5'd0, 3'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    check_vec("r0_busy", busy_vec, 32'd0);
    drive(1'b1, 1'b0, 5'd0, 3'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    check_vec("r0_no_stall", {31'd0, stallreq}, 32'd0);
    step();

    // Flush: reader of pending r7 is killed, its r9 write not recorded
    drive(1'b1, 1'b1, 5'd7, 3'd1, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    check_vec("flush_busy7", busy_vec, 32'h0000_0080);
    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 3'd2, 1'b1, 5'd7, 1'b0, 5'd0);
    check_vec("flush_no_stall", {31'd0, stallreq}, 32'd0);
    step();
    flush = 1'b0;
    idle();
    check_vec("flush_drained", busy_vec, 32'd0);

    // Back-to-back independent issues every cycle
    drive(1'b1, 1'b1, 5'd10, 3'd1, 1'b0, 5'd0, 1'b0, 5'd0);
    check_vec("b2b_0", {31'd0, stallreq}, 32'd0);
    step();
    drive(1'b1, 1'b1, 5'd11, 3'd1, 1'b1, 5'd1, 1'b0, 5'd0);
    check_vec("b2b_1", {31'd0, stallreq}, 32'd0);
    step();
    drive(1'b1, 1'b1, 5'd12, 3'd2, 1'b0, 5'd0, 1'b1, 5'd2);
    check_vec("b2b_2", {31'd0, stallreq}, 32'd0);
    step();
    check_vec("b2b_busy", busy_vec, 32'h0000_1000);
    idle();
    step(); step();

    // Saturation under a long hold, then reset mid-stall
    drive(1'b1, 1'b1, 5'd5, 3'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    hold = 1'b1;
    drive(1'b1, 1'b0, 5'd0, 3'd0, 1'b1, 5'd5, 1'b0, 5'd0);
    repeat (65541) step();
    check_vec("sat_stall_cycles", {16'd0, stall_cycles}, 32'h0000_FFFF);
    check_vec("sat_stallreq", {31'd0, stallreq}, 32'd1);
    check_vec("sat_busy", busy_vec, 32'h0000_0020);
    rst = 1'b1;
    #1;
    check_vec("rst_stallreq", {31'd0, stallreq}, 32'd0);
    step();
    check_vec("rst_busy", busy_vec, 32'd0);
    check_vec("rst_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    rst = 1'b0;
    hold = 1'b0;
    #1;
    check_vec("post_rst_no_stall", {31'd0, stallreq}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register scoreboard for the ID stage of the MIPS pipeline. It generalises the single-cycle load-use interlock to variable-latency producers (ALU, load, MUL, future multi-cycle units). It tracks a per-register countdown of cycles until each pending result is bypassable to ID, and drives the stall request to CTRL for RAW and WAW hazards. It also keeps a busy vector and a saturating stall-cycle counter for debug and performance.

## Interface

Parameters:
- REG_COUNT, 32, number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 5, register address width; REG_COUNT <= 2^ADDR_W.
- MAX_LAT, 4, largest producer latency supported, in cycles.
- LAT_W, $clog2(MAX_LAT+1), counter and latency field width.
- PERF_W, 16, stall-cycle counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- hold  in  1  downstream pipeline frozen (CTRL stall from a later stage).
- flush  in  1  kill the instruction currently in ID.
- issue_valid  in  1  ID holds a valid instruction.
- issue_wreg  in  1  instruction writes a register.
- issue_rd  in  ADDR_W  destination register.
- issue_lat  in  LAT_W  cycles after issue until the result is on a bypass path to ID (ALU 0, LW 1, MUL 2).
- src1_read, src2_read  in  1  operand read enables.
- src1_addr, src2_addr  in  ADDR_W  operand addresses.
- stallreq  out  1  combinational stall request to CTRL.
- busy_vec  out  REG_COUNT  registered; bit r = cnt[r] != 0.
- stall_cycles  out  PERF_W  registered saturating count of stalled cycles.

## Operation

- State: cnt[r] (LAT_W bits) for r = 1..REG_COUNT-1. cnt[0] is constant 0.
- Effective latency: lat_e = min(issue_lat, MAX_LAT).
- live = issue_valid & ~flush & ~rst.
- raw1 = src1_read & cnt[src1_addr] != 0. raw2 is the same for src2.
- waw = issue_wreg & issue_rd != 0 & cnt[issue_rd] > lat_e.
- stallreq = live & (raw1 | raw2 | waw).
- Accept = live & ~stallreq & ~hold.
- Per-cycle update when ~hold:
  - Every cnt[r] != 0 decrements by 1.
  - On Accept with issue_wreg, issue_rd != 0 and lat_e != 0, cnt[issue_rd] <= lat_e.
  - The issue write overrides the decrement on the same register in the same cycle.
- When hold = 1: all cnt frozen, no issue recorded. stallreq is still evaluated.
- Writes to register 0 and lat_e = 0 never create an entry.
- flush = 1 suppresses issue and stall for that cycle only. In-flight counters continue to decrement, because older instructions keep executing.
- busy_vec <= next-state nonzero mask of cnt, so it tracks cnt with no extra lag.
- stall_cycles increments when stallreq = 1. It saturates at 2^PERF_W-1 and does not wrap.
- Reset: all cnt = 0, busy_vec = 0, stall_cycles = 0. stallreq is forced 0 while rst = 1.
- Reset mid-operation discards all pending entries on the next edge.

## Timing

- stallreq has zero latency: it is combinational from current cnt and this cycle's inputs.
- An instruction accepted at edge t with lat_e = L produces cnt = L after edge t.
  - A dependent instruction in ID stalls for cycles t+1 .. t+L.
  - It proceeds in cycle t+L+1.
  - LW (L = 1) therefore gives exactly one bubble, matching the existing load-use rule.
- Back-to-back independent issues are accepted every cycle. There is no throughput loss without a hazard.
- A stalled instruction is re-evaluated every cycle. It is accepted in the first cycle in which no hazard remains and hold = 0.
- During hold, stall duration is extended one-for-one by the held cycles.

## Test plan

- Reset, then issue LW r3 (lat 1) at t0 and ADDU r4,r3,r3 from t1 -> stallreq = 1 at t1 only. ADDU is accepted at t2. busy_vec[3] = 1 after t0, 0 after t1. stall_cycles = 1.
- MUL r5 (lat 2), then an r5 reader -> 2 stall cycles. Repeat with hold = 1 for 3 cycles mid-stall -> 5 stall cycles, cnt[5] frozen at 1 during hold.
- Issue MUL r6 (lat 2), then ADDU r6,... (lat 0) with no r6 read -> WAW stall while cnt[6] > 0. Accept when cnt[6] = 0.
- Issue with issue_rd = 0, lat 3, then an r0 reader -> busy_vec = 0, never stalls.
- Pending LW r7; reader of r7 arrives with flush = 1 -> stallreq = 0, no issue recorded. cnt[7] still reaches 0 on schedule.
- Hold stallreq high for 2^16+5 cycles (PERF_W = 16) -> stall_cycles = 16'hFFFF. Assert rst mid-stall -> next cycle all outputs 0.
